// File: rtl/exec_regfile_stage.sv
// exec_regfile_stage: 32x32 register file, ALU and registered result with forwarding and valid/ready retirement
module exec_regfile_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [4:0]      rd,
  input  logic [4:0]      alu_control,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_data,
  input  logic            ld_we,
  input  logic [4:0]      ld_addr,
  input  logic [XLEN-1:0] ld_data,
  input  logic [4:0]      dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  output logic [31:0]     retired
);
  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, SLL = 5'd2, SLT = 5'd3, SLTU = 5'd4,
                         XOR = 5'd5, SRL = 5'd6, SRA = 5'd7, OR = 5'd8, AND = 5'd9;
  logic [XLEN-1:0] regs [32];
  logic [XLEN-1:0] op_a, op_b, alu;
  logic            commit, accept;
  assign commit   = out_valid && out_ready;
  assign accept   = in_valid && in_ready;
  assign in_ready = !out_valid || out_ready;
  assign dbg_data = dbg_addr == 5'd0 ? '0 : regs[dbg_addr];
  // the result committing this edge is newer than the register file
  assign op_a = (commit && out_rd == rs1 && rs1 != 5'd0) ? out_data : (rs1 == 5'd0 ? '0 : regs[rs1]);
  assign op_b = (commit && out_rd == rs2 && rs2 != 5'd0) ? out_data : (rs2 == 5'd0 ? '0 : regs[rs2]);
  always_comb begin
    alu = '0;
    case (alu_control)
      ADD:     alu = op_a + op_b;
      SUB:     alu = op_a - op_b;
      SLL:     alu = op_a << op_b[4:0];
      SLT:     alu = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      SLTU:    alu = {{(XLEN-1){1'b0}}, op_a < op_b};
      XOR:     alu = op_a ^ op_b;
      SRL:     alu = op_a >> op_b[4:0];
      SRA:     alu = $signed(op_a) >>> op_b[4:0];
      OR:      alu = op_a | op_b;
      AND:     alu = op_a & op_b;
      default: alu = '0;
    endcase
  end
  // commit is assigned last so it wins a same-register collision with the preload port
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      if (ld_we && ld_addr != 5'd0) regs[ld_addr] <= ld_data;
      if (commit && out_rd != 5'd0) regs[out_rd] <= out_data;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_rd    <= '0;
      out_data  <= '0;
      retired   <= '0;
    end else begin
      if (commit) retired <= retired + 32'd1;
      if (accept) begin
        out_valid <= 1'b1;
        out_rd    <= rd;
        out_data  <= alu;
      end else if (commit) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_exec_regfile_stage.sv
// tb_exec_regfile_stage: directed self-checking bench for exec_regfile_stage
module tb_exec_regfile_stage;
  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, SLL = 5'd2, SLT = 5'd3, SLTU = 5'd4,
                         SRL = 5'd6, SRA = 5'd7;
  logic        clk = 0, reset = 0, in_valid = 0, in_ready, out_valid, out_ready = 0, ld_we = 0;
  logic [4:0]  rs1 = 0, rs2 = 0, rd = 0, alu_control = 0, out_rd, ld_addr = 0, dbg_addr = 0;
  logic [31:0] out_data, ld_data = 0, dbg_data, retired;
  int checks = 0, failures = 0;

  exec_regfile_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .alu_control(alu_control),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic dbg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    ld_we = 1; ld_addr = a; ld_data = d;
    step();
    ld_we = 0;
  endtask

  task automatic issue(input logic [4:0] op, input logic [4:0] d, input logic [4:0] a, input logic [4:0] b);
    in_valid = 1; alu_control = op; rd = d; rs1 = a; rs2 = b;
  endtask

  initial begin
    reset = 1;
    step(); step();
    reset = 0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_retired", retired, 32'd0);

    out_ready = 1;
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd3);
    issue(ADD, 5'd3, 5'd1, 5'd2);
    step();
    chk("add_data", out_data, 32'd8);
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    issue(SUB, 5'd4, 5'd1, 5'd2);
    step();
    chk("sub_data", out_data, 32'd2);
    in_valid = 0;
    step();
    chk("commit_valid_drop", {31'd0, out_valid}, 32'd0);
    dbg("dbg_x3", 5'd3, 32'd8);
    dbg("dbg_x4", 5'd4, 32'd2);
    chk("retired_2", retired, 32'd2);

    preload(5'd1, 32'd7);
    issue(ADD, 5'd5, 5'd1, 5'd1);
    #1 chk("fwd_ready0", {31'd0, in_ready}, 32'd1);
    step();
    chk("fwd_first", out_data, 32'd14);
    issue(ADD, 5'd6, 5'd5, 5'd5);
    #1 chk("fwd_ready1", {31'd0, in_ready}, 32'd1);
    step();
    chk("fwd_second", out_data, 32'd28);
    chk("fwd_ready2", {31'd0, in_ready}, 32'd1);
    in_valid = 0;
    step();
    dbg("dbg_x6", 5'd6, 32'd28);
    chk("retired_4", retired, 32'd4);

    out_ready = 0;
    issue(ADD, 5'd8, 5'd1, 5'd1);
    step();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_data", out_data, 32'd14);
      chk("bp_out_rd", {27'd0, out_rd}, 32'd8);
      dbg("bp_no_write", 5'd8, 32'd0);
      chk("bp_retired", retired, 32'd4);
      step();
    end
    out_ready = 1;
    #1 chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp_commit_count", retired, 32'd5);
    dbg("bp_x8", 5'd8, 32'd14);
    step();
    chk("bp_single_commit", retired, 32'd5);

    preload(5'd1, 32'h8000_0000);
    preload(5'd2, 32'd33);
    issue(SRA, 5'd9, 5'd1, 5'd2);
    step();
    chk("sra", out_data, 32'hC000_0000);
    issue(SRL, 5'd10, 5'd1, 5'd2);
    step();
    chk("srl", out_data, 32'h4000_0000);
    issue(SLL, 5'd11, 5'd1, 5'd2);
    step();
    chk("sll", out_data, 32'd0);
    issue(SLT, 5'd12, 5'd1, 5'd2);
    step();
    chk("slt", out_data, 32'd1);
    issue(SLTU, 5'd13, 5'd1, 5'd2);
    step();
    chk("sltu", out_data, 32'd0);
    issue(5'd31, 5'd13, 5'd1, 5'd2);
    step();
    chk("undef_op", out_data, 32'd0);
    in_valid = 0;
    step();
    chk("retired_11", retired, 32'd11);

    issue(ADD, 5'd0, 5'd1, 5'd2);
    step();
    chk("x0_result", out_data, 32'h8000_0021);
    in_valid = 0;
    step();
    dbg("x0_reads_zero", 5'd0, 32'd0);
    chk("x0_retired", retired, 32'd12);

    issue(ADD, 5'd7, 5'd2, 5'd2);
    step();
    in_valid = 0;
    preload(5'd7, 32'h0000_DEAD);
    dbg("collide_commit_wins", 5'd7, 32'd66);
    issue(ADD, 5'd15, 5'd2, 5'd1);
    step();
    in_valid = 0;
    preload(5'd14, 32'h55);
    dbg("both_commit", 5'd15, 32'h8000_0021);
    dbg("both_load", 5'd14, 32'h55);

    out_ready = 0;
    issue(ADD, 5'd16, 5'd2, 5'd2);
    step();
    in_valid = 0;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    reset = 1;
    ld_we = 1; ld_addr = 5'd17; ld_data = 32'h1234;
    step();
    reset = 0; ld_we = 0;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_rd", {27'd0, out_rd}, 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_retired", retired, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1;
    step();
    dbg("mid_rst_x16", 5'd16, 32'd0);
    dbg("mid_rst_x3", 5'd3, 32'd0);
    dbg("rst_ignores_ld", 5'd17, 32'd0);
    chk("mid_rst_no_commit", retired, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
